// File: rtl/tt_briscv_pkg.sv
// Shared types and constants for the briscv vector unit.
// Holds the LDB allocation tracking record used by the LDB controller.
package tt_briscv_pkg;

    localparam int LDB_MAX_ALLOC_SIZE = 8;
    localparam int LDB_BASE_W         = 8;

    typedef struct packed {
        logic                  valid;
        logic [4:0]            sb_id;
        logic [LDB_BASE_W-1:0] base;
        logic [3:0]            size;
    } tt_ldb_alloc_rec_t;

endpackage

// File: rtl/tt_ldb_alloc_lookup.sv
// Age-ordered CAM over the LDB allocation records.
// The match closest to the queue head wins; no hit drives zeros.
module tt_ldb_alloc_lookup
    import tt_briscv_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 4,
    localparam int QW = $clog2(N)
) (
    input  tt_ldb_alloc_rec_t recs [N],
    input  logic [QW-1:0]     head,
    input  logic [4:0]        key,
    output logic              hit,
    output logic [IW-1:0]     base,
    output logic [3:0]        size
);

    logic [QW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        base = '0;
        size = '0;
        idx  = head;
        for (int k = 0; k < N; k++) begin
            idx = head + QW'(k);
            if (!hit && recs[idx].valid && recs[idx].sb_id == key) begin
                hit  = 1'b1;
                base = IW'(recs[idx].base);
                size = recs[idx].size;
            end
        end
    end

endmodule

// File: rtl/tt_ldb_alloc_ctrl.sv
// Load Data Buffer allocation controller: circular in-order slot grants,
// per-load tracking by scoreboard id, lookup for returns, in-order free.
module tt_ldb_alloc_ctrl
    import tt_briscv_pkg::*;
#(
    parameter int LDB_ENTRIES     = 16,
    parameter int MAX_OUTSTANDING = 4,
    localparam int IW = $clog2(LDB_ENTRIES),
    localparam int QW = $clog2(MAX_OUTSTANDING),
    localparam int CW = IW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ldb_alloc_valid,
    input  logic [4:0]    ldb_alloc_sb_id,
    input  logic [3:0]    ldb_alloc_size,
    output logic          ldb_alloc_ack,
    output logic [IW-1:0] ldb_alloc_base,
    input  logic          ldb_release_valid,
    input  logic [4:0]    ldb_release_sb_id,
    output logic          ldb_release_err,
    input  logic [4:0]    lookup_sb_id,
    output logic          lookup_hit,
    output logic [IW-1:0] lookup_base,
    output logic [3:0]    lookup_size,
    input  logic          flush,
    output logic [CW-1:0] ldb_free_count,
    output logic          ldb_busy
);

    logic [IW-1:0]     alloc_ptr;
    logic [IW-1:0]     free_ptr;
    logic [CW-1:0]     free_count;
    logic [QW:0]       wr_ptr;
    logic [QW:0]       rd_ptr;
    tt_ldb_alloc_rec_t recs [MAX_OUTSTANDING];
    logic              release_err;

    logic [QW-1:0] wr_idx;
    logic [QW-1:0] rd_idx;
    logic          q_empty;
    logic          q_full;
    logic          size_legal;
    logic [CW-1:0] size_ext;
    logic [CW-1:0] head_size_ext;
    logic          grant;
    logic          rel_match;
    logic          rel_pop;
    logic          rel_bad;

    assign wr_idx  = wr_ptr[QW-1:0];
    assign rd_idx  = rd_ptr[QW-1:0];
    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[QW] != rd_ptr[QW]) && (wr_idx == rd_idx);

    assign size_ext      = CW'(ldb_alloc_size);
    assign head_size_ext = CW'(recs[rd_idx].size);
    assign size_legal    = (ldb_alloc_size != 4'd0) &&
                           (ldb_alloc_size <= 4'(LDB_MAX_ALLOC_SIZE));

    // free_count is the registered value; a same-cycle release is not bypassed
    assign grant = ldb_alloc_valid && !flush && size_legal &&
                   (size_ext <= free_count) && !q_full;

    assign rel_match = !q_empty && (recs[rd_idx].sb_id == ldb_release_sb_id);
    assign rel_pop   = ldb_release_valid && !flush && rel_match;
    assign rel_bad   = ldb_release_valid && !flush && !rel_match;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_ptr  <= '0;
            free_ptr   <= '0;
            free_count <= CW'(LDB_ENTRIES);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else if (flush) begin
            alloc_ptr  <= '0;
            free_ptr   <= '0;
            free_count <= CW'(LDB_ENTRIES);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (grant) begin
                alloc_ptr <= alloc_ptr + IW'(ldb_alloc_size);
                wr_ptr    <= wr_ptr + (QW+1)'(1);
            end
            if (rel_pop) begin
                free_ptr <= free_ptr + IW'(recs[rd_idx].size);
                rd_ptr   <= rd_ptr + (QW+1)'(1);
            end
            free_count <= free_count
                        + (rel_pop ? head_size_ext : '0)
                        - (grant ? size_ext : '0);
        end
    end

    // Push and pop never alias: a pop needs non-empty, a push needs non-full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                recs[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                recs[i] <= '0;
        end else begin
            if (rel_pop)
                recs[rd_idx].valid <= 1'b0;
            if (grant)
                recs[wr_idx] <= '{valid: 1'b1,
                                  sb_id: ldb_alloc_sb_id,
                                  base:  LDB_BASE_W'(alloc_ptr),
                                  size:  ldb_alloc_size};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            release_err <= 1'b0;
        else if (rel_bad)
            release_err <= 1'b1;
    end

    tt_ldb_alloc_lookup #(
        .N  (MAX_OUTSTANDING),
        .IW (IW)
    ) u_lookup (
        .recs (recs),
        .head (rd_idx),
        .key  (lookup_sb_id),
        .hit  (lookup_hit),
        .base (lookup_base),
        .size (lookup_size)
    );

    assign ldb_alloc_ack   = grant;
    assign ldb_alloc_base  = alloc_ptr;
    assign ldb_release_err = release_err;
    assign ldb_free_count  = free_count;
    assign ldb_busy        = !q_empty;

endmodule

// File: tb/tb_tt_ldb_alloc_ctrl.sv
// Directed vector bench for tt_ldb_alloc_ctrl (16 slots, 4 outstanding).
// Each row is driven after a falling edge and checked before the rising edge.
module tb_tt_ldb_alloc_ctrl;

    logic       clk;
    logic       reset_n;
    logic       ldb_alloc_valid;
    logic [4:0] ldb_alloc_sb_id;
    logic [3:0] ldb_alloc_size;
    logic       ldb_alloc_ack;
    logic [3:0] ldb_alloc_base;
    logic       ldb_release_valid;
    logic [4:0] ldb_release_sb_id;
    logic       ldb_release_err;
    logic [4:0] lookup_sb_id;
    logic       lookup_hit;
    logic [3:0] lookup_base;
    logic [3:0] lookup_size;
    logic       flush;
    logic [4:0] ldb_free_count;
    logic       ldb_busy;

    int n_checks = 0;
    int n_fails  = 0;

    tt_ldb_alloc_ctrl #(
        .LDB_ENTRIES     (16),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ldb_alloc_valid   (ldb_alloc_valid),
        .ldb_alloc_sb_id   (ldb_alloc_sb_id),
        .ldb_alloc_size    (ldb_alloc_size),
        .ldb_alloc_ack     (ldb_alloc_ack),
        .ldb_alloc_base    (ldb_alloc_base),
        .ldb_release_valid (ldb_release_valid),
        .ldb_release_sb_id (ldb_release_sb_id),
        .ldb_release_err   (ldb_release_err),
        .lookup_sb_id      (lookup_sb_id),
        .lookup_hit        (lookup_hit),
        .lookup_base       (lookup_base),
        .lookup_size       (lookup_size),
        .flush             (flush),
        .ldb_free_count    (ldb_free_count),
        .ldb_busy          (ldb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int av, asb, asz, rv, rsb, lsb, fl;
        int ack, base, fc, busy, hit, lb, ls, err;
    } vec_t;

    localparam int NV = 38;
    vec_t vt [NV];

    function automatic vec_t mk(int av, int asb, int asz, int rv, int rsb,
                                int lsb, int fl, int ack, int base, int fc,
                                int busy, int hit, int lb, int ls, int err);
        vec_t v;
        v.av = av; v.asb = asb; v.asz = asz; v.rv = rv; v.rsb = rsb;
        v.lsb = lsb; v.fl = fl; v.ack = ack; v.base = base; v.fc = fc;
        v.busy = busy; v.hit = hit; v.lb = lb; v.ls = ls; v.err = err;
        return v;
    endfunction

    task automatic check(string nm, int row, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL row %0d %s: got %0d expected %0d", row, nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        ldb_alloc_valid   = v.av[0];
        ldb_alloc_sb_id   = v.asb[4:0];
        ldb_alloc_size    = v.asz[3:0];
        ldb_release_valid = v.rv[0];
        ldb_release_sb_id = v.rsb[4:0];
        lookup_sb_id      = v.lsb[4:0];
        flush             = v.fl[0];
    endtask

    task automatic check_all(int row, vec_t v);
        check("ack",   row, int'(ldb_alloc_ack),   v.ack);
        check("base",  row, int'(ldb_alloc_base),  v.base);
        check("fcnt",  row, int'(ldb_free_count),  v.fc);
        check("busy",  row, int'(ldb_busy),        v.busy);
        check("hit",   row, int'(lookup_hit),      v.hit);
        check("lbase", row, int'(lookup_base),     v.lb);
        check("lsize", row, int'(lookup_size),     v.ls);
        check("err",   row, int'(ldb_release_err), v.err);
    endtask

    initial begin
        vec_t idle;
        //          av asb asz rv rsb lsb fl  ack base fc busy hit lb ls err
        vt[0]  = mk(0, 0, 0,  0, 0, 3, 0,   0, 0, 16, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 3, 4,  0, 0, 3, 0,   1, 0, 16, 0, 0, 0, 0, 0);
        vt[2]  = mk(0, 0, 0,  0, 0, 3, 0,   0, 4, 12, 1, 1, 0, 4, 0);
        vt[3]  = mk(0, 0, 0,  1, 3, 3, 1,   0, 4, 12, 1, 1, 0, 4, 0);
        vt[4]  = mk(0, 0, 0,  0, 0, 3, 0,   0, 0, 16, 0, 0, 0, 0, 0);
        vt[5]  = mk(1, 7, 8,  0, 0, 7, 0,   1, 0, 16, 0, 0, 0, 0, 0);
        vt[6]  = mk(1, 8, 4,  0, 0, 7, 0,   1, 8,  8, 1, 1, 0, 8, 0);
        vt[7]  = mk(1, 9, 8,  0, 0, 8, 0,   0, 12, 4, 1, 1, 8, 4, 0);
        vt[8]  = mk(1, 9, 8,  1, 7, 8, 0,   0, 12, 4, 1, 1, 8, 4, 0);
        vt[9]  = mk(1, 9, 8,  0, 0, 9, 0,   1, 12, 12, 1, 0, 0, 0, 0);
        vt[10] = mk(0, 0, 0,  0, 0, 9, 0,   0, 4,  4, 1, 1, 12, 8, 0);
        vt[11] = mk(0, 0, 0,  1, 8, 9, 0,   0, 4,  4, 1, 1, 12, 8, 0);
        vt[12] = mk(0, 0, 0,  1, 9, 9, 0,   0, 4,  8, 1, 1, 12, 8, 0);
        vt[13] = mk(0, 0, 0,  0, 0, 9, 0,   0, 4, 16, 0, 0, 0, 0, 0);
        vt[14] = mk(1, 1, 1,  0, 0, 1, 0,   1, 4, 16, 0, 0, 0, 0, 0);
        vt[15] = mk(1, 2, 1,  0, 0, 1, 0,   1, 5, 15, 1, 1, 4, 1, 0);
        vt[16] = mk(1, 3, 1,  0, 0, 2, 0,   1, 6, 14, 1, 1, 5, 1, 0);
        vt[17] = mk(1, 4, 1,  0, 0, 4, 0,   1, 7, 13, 1, 0, 0, 0, 0);
        vt[18] = mk(1, 5, 1,  0, 0, 4, 0,   0, 8, 12, 1, 1, 7, 1, 0);
        vt[19] = mk(1, 5, 1,  1, 1, 4, 0,   0, 8, 12, 1, 1, 7, 1, 0);
        vt[20] = mk(1, 5, 1,  0, 0, 5, 0,   1, 8, 13, 1, 0, 0, 0, 0);
        vt[21] = mk(0, 0, 0,  1, 2, 5, 0,   0, 9, 12, 1, 1, 8, 1, 0);
        vt[22] = mk(0, 0, 0,  1, 3, 5, 0,   0, 9, 13, 1, 1, 8, 1, 0);
        vt[23] = mk(0, 0, 0,  1, 4, 5, 0,   0, 9, 14, 1, 1, 8, 1, 0);
        vt[24] = mk(0, 0, 0,  1, 5, 5, 0,   0, 9, 15, 1, 1, 8, 1, 0);
        vt[25] = mk(1, 10, 2, 0, 0, 10, 0,  1, 9, 16, 0, 0, 0, 0, 0);
        vt[26] = mk(1, 11, 3, 1, 10, 10, 0, 1, 11, 14, 1, 1, 9, 2, 0);
        vt[27] = mk(0, 0, 0,  0, 0, 11, 0,  0, 14, 13, 1, 1, 11, 3, 0);
        vt[28] = mk(0, 0, 0,  1, 9, 11, 0,  0, 14, 13, 1, 1, 11, 3, 0);
        vt[29] = mk(0, 0, 0,  0, 0, 11, 0,  0, 14, 13, 1, 1, 11, 3, 1);
        vt[30] = mk(1, 12, 0, 0, 0, 11, 0,  0, 14, 13, 1, 1, 11, 3, 1);
        vt[31] = mk(1, 12, 9, 0, 0, 11, 0,  0, 14, 13, 1, 1, 11, 3, 1);
        vt[32] = mk(1, 12, 1, 1, 11, 11, 1, 0, 14, 13, 1, 1, 11, 3, 1);
        vt[33] = mk(0, 0, 0,  0, 0, 11, 0,  0, 0, 16, 0, 0, 0, 0, 1);
        vt[34] = mk(1, 6, 2,  0, 0, 6, 0,   1, 0, 16, 0, 0, 0, 0, 1);
        vt[35] = mk(1, 6, 3,  0, 0, 6, 0,   1, 2, 14, 1, 1, 0, 2, 1);
        vt[36] = mk(0, 0, 0,  1, 6, 6, 0,   0, 5, 11, 1, 1, 0, 2, 1);
        vt[37] = mk(0, 0, 0,  0, 0, 6, 0,   0, 5, 13, 1, 1, 2, 3, 1);

        idle = mk(0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int r = 0; r < NV; r++) begin
            @(negedge clk);
            drive(vt[r]);
            #1;
            check_all(r, vt[r]);
        end

        // Asynchronous reset mid-stream: one allocation still outstanding
        @(negedge clk);
        drive(idle);
        #1;
        check("pre_rst_busy", 100, int'(ldb_busy), 1);
        reset_n = 1'b0;
        #1;
        check_all(101, mk(0, 0, 0, 0, 0, 6, 0, 0, 0, 16, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;

        // Release on an empty queue raises the sticky error
        @(negedge clk);
        ldb_release_valid = 1'b1;
        ldb_release_sb_id = 5'd4;
        #1;
        check("empty_rel_err_pre", 102, int'(ldb_release_err), 0);
        @(negedge clk);
        drive(idle);
        #1;
        check("empty_rel_err", 103, int'(ldb_release_err), 1);
        check("empty_rel_fcnt", 103, int'(ldb_free_count), 16);
        check("empty_rel_busy", 103, int'(ldb_busy), 0);
        @(negedge clk);
        #1;
        check("err_sticky", 104, int'(ldb_release_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
